// File: rtl/psdsqrt_seq_if.sv
// Radicand input stream and root output stream between psdsqrt_seq and its neighbours.
// slave is the sequencer's view, master is the upstream/downstream side.
interface psdsqrt_seq_if #(
    parameter int NBITSIN = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NBITSIN-1:0]     in_x;
    logic                   out_valid;
    logic                   out_ready;
    logic [NBITSIN/2-1:0]   out_sqrt;
    logic [NBITSIN-1:0]     out_x;
    logic                   out_err;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_sqrt, out_x, out_err
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_sqrt, out_x, out_err
    );
endinterface

// File: rtl/psdsqrt_seq.sv
// Sequencer around the psdsqrt core: issues start/stop pulses, captures the root,
// checks it against integer-sqrt bounds and hands it downstream.
module psdsqrt_seq #(
    parameter int NBITSIN    = 32,
    parameter int STOP_DELAY = NBITSIN/2 + 1,
    parameter int CNTW       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    psdsqrt_seq_if.slave          bus,
    input  logic                  abort,
    output logic                  core_start,
    output logic                  core_stop,
    output logic [NBITSIN-1:0]    core_xin,
    input  logic [NBITSIN/2-1:0]  core_sqrt,
    output logic                  busy,
    output logic [CNTW-1:0]       done_count
);
    localparam int HW = NBITSIN/2;
    localparam int CW = $clog2(STOP_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RUN, S_STOP, S_CAPTURE, S_OUT
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NBITSIN-1:0] xreg_q, xreg_d;
    logic [NBITSIN-1:0] out_x_q, out_x_d;
    logic [HW-1:0]      out_sqrt_q, out_sqrt_d;
    logic               out_err_q, out_err_d;
    logic [CNTW-1:0]    done_q, done_d;

    // Bound check one bit wider than the radicand so (s+1)^2 = 2^NBITSIN still fits.
    logic [NBITSIN:0]   s_w, s1_w, sq_lo, sq_hi, x_w;
    logic               bound_ok;

    assign s_w      = {{(NBITSIN + 1 - HW){1'b0}}, core_sqrt};
    assign s1_w     = s_w + (NBITSIN + 1)'(1);
    assign sq_lo    = s_w * s_w;
    assign sq_hi    = s1_w * s1_w;
    assign x_w      = {1'b0, xreg_q};
    assign bound_ok = (sq_lo <= x_w) && (x_w < sq_hi);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        xreg_d     = xreg_q;
        out_x_d    = out_x_q;
        out_sqrt_d = out_sqrt_q;
        out_err_d  = out_err_q;
        done_d     = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    xreg_d  = bus.in_x;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = CW'(STOP_DELAY - 1);
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (abort)                 state_d = S_IDLE;
                else if (cnt_q == CW'(1))  state_d = S_STOP;
            end
            S_STOP: begin
                state_d = abort ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                out_sqrt_d = core_sqrt;
                out_x_d    = xreg_q;
                out_err_d  = !bound_ok;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    done_d  = done_q + CNTW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            xreg_q     <= '0;
            out_x_q    <= '0;
            out_sqrt_q <= '0;
            out_err_q  <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            xreg_q     <= xreg_d;
            out_x_q    <= out_x_d;
            out_sqrt_q <= out_sqrt_d;
            out_err_q  <= out_err_d;
            done_q     <= done_d;
        end
    end

    // Pulses and handshakes are pure state decodes, so reset clears them at once.
    assign core_start    = (state_q == S_START);
    assign core_stop     = (state_q == S_STOP);
    assign busy          = (state_q != S_IDLE);
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_sqrt  = out_sqrt_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_err   = out_err_q;
    assign core_xin      = xreg_q;
    assign done_count    = done_q;
endmodule

// File: tb/tb_psdsqrt_seq.sv
// Randomized self-checking bench for psdsqrt_seq with a behavioural psdsqrt core
// that loads floor(sqrt(xin)) on core_stop.
module tb_psdsqrt_seq;
    localparam int NB = 32;
    localparam int SD = NB/2 + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            abort;
    logic            core_start, core_stop, busy;
    logic [NB-1:0]   core_xin;
    logic [NB/2-1:0] core_sqrt = '0;
    logic [15:0]     done_count;

    int              n_checks = 0;
    int              n_errors = 0;
    int              exp_done = 0;
    int              cyc_cnt  = 0;
    int              last_accept = 0;
    int              last_bp  = 1;
    bit              force_en = 1'b0;
    logic [15:0]     force_val = '0;

    psdsqrt_seq_if #(.NBITSIN(NB)) bus ();

    psdsqrt_seq dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .abort      (abort),
        .core_start (core_start),
        .core_stop  (core_stop),
        .core_xin   (core_xin),
        .core_sqrt  (core_sqrt),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned lo = 0, hi = 65536, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    // Behavioural core: output register loads on the stop pulse.
    always @(posedge clock)
        if (core_stop) core_sqrt <= force_en ? force_val : 16'(isqrt(64'(core_xin)));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge; IDLE on entry.
    task automatic run_op(input logic [31:0] x, input int bp, input bit b2b);
        longint unsigned s, xl;
        logic            e;
        int              cyc, start_at, stop_at, nstart, nstop, bad_ready, bad_xin;
        logic [15:0]     h_sqrt;
        logic [31:0]     h_x;
        logic            h_err;
        xl = 64'(x);
        s  = force_en ? 64'(force_val) : isqrt(xl);
        e  = !((s * s <= xl) && (xl < (s + 1) * (s + 1)));

        bus.in_valid  = 1'b1;
        bus.in_x      = x;
        bus.out_ready = (bp == 0);
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin @(negedge clock); cyc++; end
        check("in_ready_idle", bus.in_ready, 1);
        @(posedge clock);
        if (b2b && last_bp == 0) check("accept_spacing", cyc_cnt + 1 - last_accept, SD + 4);
        last_accept = cyc_cnt + 1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_x     = $urandom;

        cyc = 0; start_at = -1; stop_at = -1; nstart = 0; nstop = 0; bad_ready = 0; bad_xin = 0;
        while (!bus.out_valid && cyc < SD + 10) begin
            if (core_start) begin nstart++; start_at = cyc; end
            if (core_stop)  begin nstop++;  stop_at  = cyc; end
            if (bus.in_ready)   bad_ready++;
            if (core_xin !== x) bad_xin++;
            @(negedge clock);
            cyc++;
        end
        check("valid_cycle", cyc, SD + 2);
        check("start_cycle", start_at, 0);
        check("stop_cycle",  stop_at, SD);
        check("pulse_count", nstart + nstop, 2);
        check("busy_ready",  bad_ready, 0);
        check("core_xin",    bad_xin, 0);
        check("out_sqrt",    bus.out_sqrt, s);
        check("out_x",       bus.out_x, x);
        check("out_err",     bus.out_err, e);

        h_sqrt = bus.out_sqrt; h_x = bus.out_x; h_err = bus.out_err;
        for (int i = 1; i <= bp; i++) begin
            @(negedge clock);
            check("bp_hold", {bus.out_valid, bus.in_ready, h_sqrt == bus.out_sqrt,
                              h_x == bus.out_x, h_err == bus.out_err}, 5'b10111);
            if (i == bp) bus.out_ready = 1'b1;
        end
        check("done_before", done_count, 16'(exp_done));
        @(posedge clock);
        exp_done++;
        @(negedge clock);
        check("after_hs", {bus.out_valid, bus.in_ready, busy}, 3'b010);
        check("done_count", done_count, 16'(exp_done));
        last_bp = bp;
    endtask

    initial begin
        int seen;
        logic [31:0] rx;
        reset = 1'b0; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_pulses", {core_start, core_stop, bus.out_valid, busy}, 4'b0000);
        check("rst_out_err", bus.out_err, 0);
        check("rst_out_sqrt", bus.out_sqrt, 0);
        check("rst_out_x", bus.out_x, 0);
        check("rst_core_xin", core_xin, 0);
        check("rst_done", done_count, 0);
        reset = 1'b1;
        #1 check("rst_in_ready", bus.in_ready, 1);
        @(negedge clock);

        run_op(32'd123456, 0, 0);
        run_op(32'd0, 0, 1);
        run_op(32'd1, 0, 1);
        run_op(32'hFFFF_FFFF, 0, 1);
        run_op($urandom, 5, 1);

        // Abort in RUN cycle 5.
        bus.in_valid = 1'b1; bus.in_x = $urandom; bus.out_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clock);
        check("abort_busy_before", busy, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_idle", {busy, bus.in_ready}, 2'b01);
        seen = 0;
        repeat (SD + 4) begin
            if (core_stop || bus.out_valid) seen++;
            @(negedge clock);
        end
        check("abort_no_stop", seen, 0);
        check("abort_done", done_count, 16'(exp_done));
        run_op(32'd144, 0, 0);

        // Asynchronous reset mid-RUN.
        bus.in_valid = 1'b1; bus.in_x = $urandom;
        @(posedge clock); @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_pulses", {busy, core_start, core_stop, bus.out_valid}, 4'b0000);
        check("arst_done", done_count, 0);
        exp_done = 0;
        @(negedge clock);
        reset = 1'b1;
        run_op(32'd99980001, 0, 0);

        // Checker: wrong root from the core.
        force_en = 1'b1; force_val = 16'd352;
        run_op(32'd123456, 0, 0);
        force_en = 1'b0;

        for (int k = 0; k < 20; k++) begin
            rx = $urandom;
            rx = rx >> $urandom_range(0, 31);
            run_op(rx, $urandom_range(0, 3), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end
endmodule
